// File: rtl/input_debouncer.sv
// input_debouncer
// Turns a raw asynchronous pin into a clean level in the clk domain. The pin
// goes through a SYNC_STAGES-deep synchronizer. A settle FSM then commits a
// new level only after the synchronized value has held for STABLE_CYCLES
// consecutive samples. Every qualification that is abandoned early is counted
// in a saturating diagnostic counter.
//
// Ports
//   clk         sole clock
//   reset       asynchronous, active-high reset
//   in          raw asynchronous pin
//   clr_glitch  synchronous clear of glitch_cnt (wins over a coincident abort)
//   out         debounced level (registered)
//   settling    high while a candidate level is being qualified (registered)
//   glitch_cnt  saturating count of aborted transitions (registered)
module input_debouncer #(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned STABLE_CYCLES = 1000,
  parameter int unsigned GLITCH_W      = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in,
  input  logic                clr_glitch,
  output logic                out,
  output logic                settling,
  output logic [GLITCH_W-1:0] glitch_cnt
);

  localparam int unsigned         CNT_W      = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0]    CNT_LAST   = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [GLITCH_W-1:0] GLITCH_MAX = '1;

  typedef enum logic [1:0] {
    STABLE_LOW,
    WAIT_HIGH,
    STABLE_HIGH,
    WAIT_LOW
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   out_d;
  logic                   settling_d;
  logic [GLITCH_W-1:0]    glitch_d;
  logic                   abort;

  // Synchronizer chain; only the last stage is used downstream.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], in};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // State, qualification counter and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= STABLE_LOW;
      cnt_q      <= '0;
      out        <= 1'b0;
      settling   <= 1'b0;
      glitch_cnt <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      out        <= out_d;
      settling   <= settling_d;
      glitch_cnt <= glitch_d;
    end
  end

  // Next-state, counter and output decode.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    out_d    = out;
    glitch_d = glitch_cnt;
    abort    = 1'b0;

    case (state_q)
      STABLE_LOW: begin
        if (s) begin
          // A one-cycle qualification window commits on the first sample.
          if (STABLE_CYCLES == 1) begin
            out_d   = 1'b1;
            state_d = STABLE_HIGH;
          end else begin
            state_d = WAIT_HIGH;
            cnt_d   = CNT_W'(1);
          end
        end
      end

      WAIT_HIGH: begin
        if (s) begin
          if (cnt_q == CNT_LAST) begin
            out_d   = 1'b1;
            state_d = STABLE_HIGH;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          abort   = 1'b1;
          state_d = STABLE_LOW;
          cnt_d   = '0;
        end
      end

      STABLE_HIGH: begin
        if (!s) begin
          if (STABLE_CYCLES == 1) begin
            out_d   = 1'b0;
            state_d = STABLE_LOW;
          end else begin
            state_d = WAIT_LOW;
            cnt_d   = CNT_W'(1);
          end
        end
      end

      WAIT_LOW: begin
        if (!s) begin
          if (cnt_q == CNT_LAST) begin
            out_d   = 1'b0;
            state_d = STABLE_LOW;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          abort   = 1'b1;
          state_d = STABLE_HIGH;
          cnt_d   = '0;
        end
      end

      default: begin
        state_d = STABLE_LOW;
        cnt_d   = '0;
      end
    endcase

    // Clear has priority over a coincident abort; the count never wraps.
    if (clr_glitch) begin
      glitch_d = '0;
    end else if (abort && (glitch_cnt != GLITCH_MAX)) begin
      glitch_d = glitch_cnt + GLITCH_W'(1);
    end

    settling_d = (state_d == WAIT_HIGH) || (state_d == WAIT_LOW);
  end

endmodule

// File: tb/tb_input_debouncer.sv
// Bench for input_debouncer: table-driven vectors, hand sequences for
// multi-cycle corners, and randomized bouncing input checked against a
// behavioural model of the debounce rules.
module tb_input_debouncer;

  localparam int unsigned SYNC_A = 2;
  localparam int unsigned STAB_A = 4;
  localparam int unsigned LOG_N  = 8192;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // DUT A: SYNC=2, STABLE=4, GLITCH_W=8
  logic       in_a, clr_a, out_a, settling_a;
  logic [7:0] glitch_a;
  // DUT B: SYNC=2, STABLE=1
  logic       in_b, clr_b, out_b, settling_b;
  logic [7:0] glitch_b;
  // DUT C: SYNC=3, STABLE=4, GLITCH_W=2
  logic       in_c, clr_c, out_c, settling_c;
  logic [1:0] glitch_c;

  input_debouncer #(.SYNC_STAGES(SYNC_A), .STABLE_CYCLES(STAB_A), .GLITCH_W(8)) dut_a (
    .clk(clk), .reset(reset), .in(in_a), .clr_glitch(clr_a),
    .out(out_a), .settling(settling_a), .glitch_cnt(glitch_a));

  input_debouncer #(.SYNC_STAGES(2), .STABLE_CYCLES(1), .GLITCH_W(8)) dut_b (
    .clk(clk), .reset(reset), .in(in_b), .clr_glitch(clr_b),
    .out(out_b), .settling(settling_b), .glitch_cnt(glitch_b));

  input_debouncer #(.SYNC_STAGES(3), .STABLE_CYCLES(4), .GLITCH_W(2)) dut_c (
    .clk(clk), .reset(reset), .in(in_c), .clr_glitch(clr_c),
    .out(out_c), .settling(settling_c), .glitch_cnt(glitch_c));

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Behavioural model of DUT A: the FSM at edge k sees the pin value captured
  // SYNC_A edges earlier; a level is adopted once STAB_A consecutive samples
  // disagree with it, and a disagreeing run cut short is one glitch.
  logic       in_log [LOG_N];
  int         cyc;
  logic       m_out;
  int         m_run;
  logic [7:0] m_g;

  initial begin
    logic v;
    cyc   = 0;
    m_out = 1'b0;
    m_run = 0;
    m_g   = 8'd0;
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        cyc   = 0;
        m_out = 1'b0;
        m_run = 0;
        m_g   = 8'd0;
      end else begin
        v = (cyc >= int'(SYNC_A)) ? in_log[(cyc - int'(SYNC_A)) % LOG_N] : 1'b0;
        in_log[cyc % LOG_N] = in_a;
        if (v != m_out) begin
          m_run++;
          if (m_run == int'(STAB_A)) begin
            m_out = v;
            m_run = 0;
          end
        end else begin
          if (m_run > 0 && m_g != 8'hFF) m_g++;
          m_run = 0;
        end
        if (clr_a) m_g = 8'd0;
        cyc++;
      end
    end
  end

  // Continuous comparison of DUT A against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        check("model_out", 32'(out_a), 32'(m_out));
        check("model_settling", 32'(settling_a), 32'(m_run > 0));
        check("model_glitch", 32'(glitch_a), 32'(m_g));
      end
    end
  end

  typedef struct {
    logic       in;
    logic       clr;
    logic       out;
    logic       settling;
    logic [7:0] glitch;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic i, input logic c, input logic o, input logic s, input logic [7:0] g);
    vec_t v;
    v.in = i; v.clr = c; v.out = o; v.settling = s; v.glitch = g;
    vq.push_back(v);
  endtask

  initial begin
    int n;
    int hold;
    logic lvl;
    logic exp_b [8];

    in_a = 1'b0; clr_a = 1'b0;
    in_b = 1'b0; clr_b = 1'b0;
    in_c = 1'b0; clr_c = 1'b0;

    // Clean rising step: out after edge 6, settling after edges 3..5.
    add(1,0,0,0,0); add(1,0,0,0,0); add(1,0,0,1,0); add(1,0,0,1,0);
    add(1,0,0,1,0); add(1,0,1,0,0); add(1,0,1,0,0); add(1,0,1,0,0);
    // Falling edge with one bounce: 0,0,1 then 0 steady.
    add(0,0,1,0,0); add(0,0,1,0,0); add(1,0,1,1,0); add(0,0,1,1,0);
    add(0,0,1,0,1); add(0,0,1,1,1); add(0,0,1,1,1); add(0,0,1,1,1);
    add(0,0,0,0,1); add(0,0,0,0,1);
    // Clear the counter.
    add(0,1,0,0,0); add(0,0,0,0,0);
    // Bounce rejection: 1,1,0,0,1,1,0,0 then 0 steady gives two glitches.
    add(1,0,0,0,0); add(1,0,0,0,0); add(0,0,0,1,0); add(0,0,0,1,0);
    add(1,0,0,0,1); add(1,0,0,0,1); add(0,0,0,1,1); add(0,0,0,1,1);
    add(0,0,0,0,2); add(0,0,0,0,2); add(0,0,0,0,2);

    // Reset state of all instances.
    step(2);
    check("rst_out_a", 32'(out_a), 0);
    check("rst_settling_a", 32'(settling_a), 0);
    check("rst_glitch_a", 32'(glitch_a), 0);
    check("rst_out_b", 32'(out_b), 0);
    check("rst_out_c", 32'(out_c), 0);
    check("rst_glitch_c", 32'(glitch_c), 0);
    reset = 1'b0;

    foreach (vq[i]) begin
      in_a  = vq[i].in;
      clr_a = vq[i].clr;
      step(1);
      check($sformatf("vec%0d_out", i), 32'(out_a), 32'(vq[i].out));
      check($sformatf("vec%0d_settling", i), 32'(settling_a), 32'(vq[i].settling));
      check($sformatf("vec%0d_glitch", i), 32'(glitch_a), 32'(vq[i].glitch));
    end
    clr_a = 1'b0;

    // STABLE_CYCLES=1: one-cycle pin pulse reaches out two edges after capture.
    exp_b = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    in_b = 1'b1;
    step(1);
    in_b = 1'b0;
    check("b_out_0", 32'(out_b), 32'(exp_b[0]));
    for (int k = 1; k < 8; k++) begin
      step(1);
      check($sformatf("b_out_%0d", k), 32'(out_b), 32'(exp_b[k]));
      check($sformatf("b_settling_%0d", k), 32'(settling_b), 0);
      check($sformatf("b_glitch_%0d", k), 32'(glitch_b), 0);
    end

    // Saturation at 3 on a 2-bit counter, then clear coinciding with an abort.
    for (int k = 0; k < 6; k++) begin
      in_c = 1'b1;
      step(2);
      in_c = 1'b0;
      step(3);
      check($sformatf("c_settling_pre_abort%0d", k), 32'(settling_c), 1);
      clr_c = (k == 5);
      step(1);
      clr_c = 1'b0;
      check($sformatf("c_glitch_abort%0d", k), 32'(glitch_c), (k == 5) ? 0 : ((k + 1 > 3) ? 3 : k + 1));
      check($sformatf("c_settling_abort%0d", k), 32'(settling_c), 0);
      check($sformatf("c_out_abort%0d", k), 32'(out_c), 0);
      step(2);
    end

    // Reset mid-settle on DUT A with cnt=2, then requalify from reset.
    in_a = 1'b1;
    step(4);
    check("mid_settling", 32'(settling_a), 1);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_out", 32'(out_a), 0);
    check("mid_rst_settling", 32'(settling_a), 0);
    check("mid_rst_glitch", 32'(glitch_a), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    n = 0;
    while (out_a == 1'b0 && n < 20) begin
      step(1);
      n++;
    end
    check("post_rst_latency", 32'(n), 32'(SYNC_A + STAB_A));
    check("post_rst_glitch", 32'(glitch_a), 0);

    // Randomized bouncing pin with occasional clears, checked by the model.
    lvl = 1'b1;
    n = 0;
    while (n < 3000) begin
      lvl  = ~lvl;
      hold = $urandom_range(1, 6);
      for (int k = 0; k < hold; k++) begin
        in_a  = lvl;
        clr_a = ($urandom_range(0, 15) == 0);
        step(1);
        n++;
      end
    end
    clr_a = 1'b0;
    step(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
